aud_src_sched: RTL

Sample-slot scheduler for the WM8978 playback path. It shares the single 32-bit stereo DAC sample stream among three sources: LINE_IN passthrough, the ROM alert-tone generator, and a CPU-fed PCM stream. Sources are granted by fixed priority, and a silent gap is inserted on every source change to avoid clicks. It sits between the source blocks and the I2S transmitter, and advances one sample per `tx_done` strobe.

---
 rtl/aud_src_sched_if.sv | 47 ++++
 rtl/aud_src_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/aud_src_sched_if.sv
// -----------------------------------------------------------------------------
// aud_src_sched_if
// Bundles every source-side and transmitter-side signal of the playback sample
// scheduler so the scheduler and its neighbours connect through one port.
//
// Signals:
//   tx_done      : I2S transmitter consumed the current sample (1-cycle strobe)
//   line_data    : LINE_IN sample {L[15:0],R[15:0]}, always valid
//   tone_req     : alert tone requested (level)
//   tone_rd      : read strobe to the tone ROM
//   tone_data    : tone ROM word, valid one cycle after tone_rd
//   pcm_req      : CPU PCM stream requested (level)
//   pcm_valid    : PCM word available
//   pcm_data     : PCM word
//   pcm_ready    : PCM word accepted when pcm_valid && pcm_ready
//   aud_data     : registered sample towards the I2S transmitter
//   src_sel      : current grant, 0=LINE 1=TONE 2=PCM 3=GAP
//   underrun_cnt : saturating PCM underrun count
//
// Modports:
//   master : the surrounding sources and transmitter
//   slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface aud_src_sched_if;
   logic        tx_done;
   logic [31:0] line_data;
   logic        tone_req;
   logic        tone_rd;
   logic [31:0] tone_data;
   logic        pcm_req;
   logic        pcm_valid;
   logic [31:0] pcm_data;
   logic        pcm_ready;
   logic [31:0] aud_data;
   logic [1:0]  src_sel;
   logic [15:0] underrun_cnt;

   modport master (
      output tx_done, line_data, tone_req, tone_data, pcm_req, pcm_valid, pcm_data,
      input  tone_rd, pcm_ready, aud_data, src_sel, underrun_cnt
   );

   modport slave (
      input  tx_done, line_data, tone_req, tone_data, pcm_req, pcm_valid, pcm_data,
      output tone_rd, pcm_ready, aud_data, src_sel, underrun_cnt
   );
endinterface

// File: rtl/aud_src_sched.sv
// -----------------------------------------------------------------------------
// aud_src_sched
// Sample-slot scheduler for the WM8978 playback path. Shares the single 32-bit
// stereo DAC sample stream between LINE_IN passthrough, the ROM alert-tone
// generator and a CPU-fed PCM stream. The grant follows fixed priority
// (TONE > PCM > LINE) and every change of source is separated by GAP_SAMPLES
// zero samples so the DAC never jumps between unrelated waveforms.
// One sample is advanced per tx_done strobe; every sample, whatever its source,
// appears on aud_data exactly two cycles after its strobe.
//
// Parameters:
//   GAP_SAMPLES : zero samples emitted on each source switch (1..255)
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : aud_src_sched_if.slave, source/transmitter signals (see interface)
//
// Build option:
//   AUD_SCHED_UNDERRUN_CNT_EN : when defined, underrun_cnt counts PCM underruns
//                               (saturating at 16'hFFFF); otherwise it is tied
//                               to 16'd0. Underruns always produce 0 samples.
// -----------------------------------------------------------------------------
module aud_src_sched #(
   parameter int unsigned GAP_SAMPLES = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   aud_src_sched_if.slave  bus
);

   // State encoding doubles as the src_sel encoding.
   typedef enum logic [1:0] {
      ST_LINE = 2'd0,
      ST_TONE = 2'd1,
      ST_PCM  = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   // The switching strobe itself emits the first zero, so the counter starts
   // one below the gap length and the gap ends on the strobe that finds it 0.
   localparam logic [7:0] GAP_LOAD = 8'(GAP_SAMPLES - 32'd1);

   state_t      state_r;
   state_t      state_nxt_s;
   state_t      desired_s;
   state_t      fetch_s;      // source fetched at this strobe; ST_GAP = zero
   logic [7:0]  gap_cnt_r;
   logic [7:0]  gap_cnt_nxt_s;
   logic [31:0] fetch_data_s;

   // Fetch stage: one entry per strobe, resolved into aud_data one cycle later.
   logic        stg_vld_r;
   logic        stg_tone_r;   // entry waits for tone_data from the ROM
   logic [31:0] stg_data_r;
   logic [31:0] aud_data_r;

   // Priority request decode.
   always_comb begin
      desired_s = ST_LINE;
      if (bus.tone_req) begin
         desired_s = ST_TONE;
      end else if (bus.pcm_req) begin
         desired_s = ST_PCM;
      end else begin
         desired_s = ST_LINE;
      end
   end

   // Next-state, gap counter and fetch decision; only strobes move anything.
   always_comb begin
      state_nxt_s   = state_r;
      gap_cnt_nxt_s = gap_cnt_r;
      fetch_s       = ST_GAP;
      if (bus.tx_done) begin
         case (state_r)
            ST_LINE, ST_TONE, ST_PCM: begin
               if (desired_s == state_r) begin
                  fetch_s = state_r;
               end else begin
                  state_nxt_s   = ST_GAP;
                  gap_cnt_nxt_s = GAP_LOAD;
                  fetch_s       = ST_GAP;
               end
            end
            ST_GAP: begin
               // Requests are ignored until the counter runs out; then the
               // new source is entered and fetched on the same strobe.
               if (gap_cnt_r != 8'd0) begin
                  gap_cnt_nxt_s = gap_cnt_r - 8'd1;
                  fetch_s       = ST_GAP;
               end else begin
                  state_nxt_s = desired_s;
                  fetch_s     = desired_s;
               end
            end
            default: begin
               state_nxt_s   = ST_LINE;
               gap_cnt_nxt_s = 8'd0;
               fetch_s       = ST_GAP;
            end
         endcase
      end else begin
         state_nxt_s   = state_r;
         gap_cnt_nxt_s = gap_cnt_r;
         fetch_s       = ST_GAP;
      end
   end

   // Sample value known at the strobe; tone samples are filled in next cycle.
   always_comb begin
      fetch_data_s = 32'd0;
      case (fetch_s)
         ST_LINE: begin
            fetch_data_s = bus.line_data;
         end
         ST_PCM: begin
            if (bus.pcm_valid) begin
               fetch_data_s = bus.pcm_data;
            end else begin
               fetch_data_s = 32'd0;
            end
         end
         default: begin
            fetch_data_s = 32'd0;
         end
      endcase
   end

   // State and gap counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_LINE;
         gap_cnt_r <= 8'd0;
      end else begin
         state_r   <= state_nxt_s;
         gap_cnt_r <= gap_cnt_nxt_s;
      end
   end

   // Fetch stage register: remembers what this strobe fetched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_vld_r  <= 1'b0;
         stg_tone_r <= 1'b0;
         stg_data_r <= 32'd0;
      end else begin
         stg_vld_r  <= bus.tx_done;
         stg_tone_r <= bus.tx_done & (fetch_s == ST_TONE);
         if (bus.tx_done) begin
            stg_data_r <= fetch_data_s;
         end else begin
            stg_data_r <= stg_data_r;
         end
      end
   end

   // Output sample register: uniform two-cycle latency for every source.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aud_data_r <= 32'd0;
      end else if (stg_vld_r) begin
         aud_data_r <= stg_tone_r ? bus.tone_data : stg_data_r;
      end else begin
         aud_data_r <= aud_data_r;
      end
   end

`ifdef AUD_SCHED_UNDERRUN_CNT_EN
   logic        underrun_s;
   logic [15:0] underrun_cnt_r;

   assign underrun_s = bus.tx_done & (fetch_s == ST_PCM) & ~bus.pcm_valid;

   // Saturating PCM underrun counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_cnt_r <= 16'd0;
      end else if (underrun_s && (underrun_cnt_r != 16'hFFFF)) begin
         underrun_cnt_r <= underrun_cnt_r + 16'd1;
      end else begin
         underrun_cnt_r <= underrun_cnt_r;
      end
   end

   assign bus.underrun_cnt = underrun_cnt_r;
`else
   assign bus.underrun_cnt = 16'd0;
`endif

   // Read/accept strobes follow the fetch decision so the first sample of a
   // new source is requested on the strobe that leaves the gap.
   assign bus.tone_rd   = bus.tx_done & (fetch_s == ST_TONE);
   assign bus.pcm_ready = bus.tx_done & (fetch_s == ST_PCM);
   assign bus.aud_data  = aud_data_r;
   assign bus.src_sel   = state_r;

endmodule
